// File: rtl/demux_n_hs.sv
// Registered 1-to-NCH demultiplexer with valid/ready on every port.
// Words go to one channel or to all channels, and drops are counted.
module demux_n_hs #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [SELW-1:0]  Sel,
    input  logic             Bcast,
    output logic [WIDTH-1:0] Out_Data,
    output logic [NCH-1:0]   Out_Valid,
    input  logic [NCH-1:0]   Out_Ready,
    output logic             Err,
    input  logic             Err_Clr,
    output logic [7:0]       Drop_Cnt
);

    localparam logic [SELW:0]  NCH_L   = (SELW+1)'(NCH);
    localparam logic [NCH-1:0] ONE_HOT = {{(NCH-1){1'b0}}, 1'b1};

    logic [NCH-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [NCH-1:0]   done;
    logic             in_ready;
    logic             accept;
    logic             sel_ok;
    logic             drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        done     = pend_q & Out_Ready;
        // Ready once every still-pending channel is completing this cycle.
        in_ready = ((pend_q & ~Out_Ready) == '0);
        accept   = In_Valid & in_ready;
        sel_ok   = ({1'b0, Sel} < NCH_L);
        drop     = accept & ~Bcast & ~sel_ok;

        pend_d = pend_q & ~done;
        data_d = data_q;
        err_d  = err_q;
        cnt_d  = cnt_q;

        if (Err_Clr) begin
            err_d = 1'b0;
            cnt_d = 8'd0;
        end

        if (accept) begin
            if (Bcast) begin
                pend_d = '1;
                data_d = In_Data;
            end else if (sel_ok) begin
                pend_d = ONE_HOT << Sel;
                data_d = In_Data;
            end else begin
                pend_d = '0;
            end
        end

        // A drop in the same cycle as a clear leaves a count of one.
        if (drop) begin
            err_d = 1'b1;
            cnt_d = sat_inc(cnt_d);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pend_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign In_Ready  = in_ready;
    assign Out_Data  = data_q;
    assign Out_Valid = pend_q;
    assign Err       = err_q;
    assign Drop_Cnt  = cnt_q;

endmodule

// File: tb/tb_demux_n_hs.sv
// Bench for demux_n_hs: a 4-channel and a 3-channel instance checked
// cycle by cycle against a per-channel "owed delivery" model.
module tb_demux_n_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    int         act;
    logic       iv, ibc, eclr;
    logic [7:0] idata;
    logic [1:0] isel;
    logic [3:0] ordy;

    logic       iv0, bc0, clr0, rdy0, err0;
    logic [7:0] od0, cnt0;
    logic [3:0] or0, ov0;
    logic       iv1, bc1, clr1, rdy1, err1;
    logic [7:0] od1, cnt1;
    logic [2:0] or1, ov1;

    assign iv0  = (act == 0) ? iv : 1'b0;
    assign bc0  = ibc;
    assign clr0 = (act == 0) ? eclr : 1'b0;
    assign or0  = (act == 0) ? ordy : 4'hF;
    assign iv1  = (act == 1) ? iv : 1'b0;
    assign bc1  = ibc;
    assign clr1 = (act == 1) ? eclr : 1'b0;
    assign or1  = (act == 1) ? ordy[2:0] : 3'h7;

    demux_n_hs #(.WIDTH(8), .NCH(4), .SELW(2)) u4 (
        .Clk(clk), .Rst_n(rst_n), .In_Data(idata), .In_Valid(iv0), .In_Ready(rdy0),
        .Sel(isel), .Bcast(bc0), .Out_Data(od0), .Out_Valid(ov0), .Out_Ready(or0),
        .Err(err0), .Err_Clr(clr0), .Drop_Cnt(cnt0)
    );

    demux_n_hs #(.WIDTH(8), .NCH(3), .SELW(2)) u3 (
        .Clk(clk), .Rst_n(rst_n), .In_Data(idata), .In_Valid(iv1), .In_Ready(rdy1),
        .Sel(isel), .Bcast(bc1), .Out_Data(od1), .Out_Valid(ov1), .Out_Ready(or1),
        .Err(err1), .Err_Clr(clr1), .Drop_Cnt(cnt1)
    );

    int total = 0;
    int bad   = 0;

    // Model: which channels are still owed the held word, plus error state.
    bit         owe   [2][4];
    logic [7:0] mword [2];
    bit         merr  [2];
    int         mcnt  [2];
    int         nch   [2];
    bit         last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mready(input int d, input logic [3:0] r);
        for (int i = 0; i < nch[d]; i++)
            if (owe[d][i] && !r[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] mvalid(input int d);
        logic [3:0] e = 4'h0;
        for (int i = 0; i < nch[d]; i++) e[i] = owe[d][i];
        return e;
    endfunction

    function automatic logic [3:0] eff_ready(input int d);
        if (act == d) return (d == 0) ? ordy : {1'b0, ordy[2:0]};
        return 4'hF;
    endfunction

    task automatic model_clear(input int d);
        for (int i = 0; i < 4; i++) owe[d][i] = 1'b0;
        mword[d] = 8'h00;
        merr[d]  = 1'b0;
        mcnt[d]  = 0;
    endtask

    task automatic cyc();
        bit         exp_rdy [2];
        bit         v, clr, acc;
        logic [3:0] r;
        @(negedge clk);
        exp_rdy[0] = mready(0, eff_ready(0));
        exp_rdy[1] = mready(1, eff_ready(1));
        chk("in_ready4", {31'b0, rdy0}, {31'b0, exp_rdy[0]});
        chk("in_ready3", {31'b0, rdy1}, {31'b0, exp_rdy[1]});
        for (int d = 0; d < 2; d++) begin
            v   = (act == d) ? iv : 1'b0;
            clr = (act == d) ? eclr : 1'b0;
            r   = eff_ready(d);
            acc = 1'b0;
            if (!rst_n) begin
                model_clear(d);
            end else begin
                acc = v && exp_rdy[d];
                for (int i = 0; i < nch[d]; i++)
                    if (owe[d][i] && r[i]) owe[d][i] = 1'b0;
                if (clr) begin
                    merr[d] = 1'b0;
                    mcnt[d] = 0;
                end
                if (acc) begin
                    if (ibc) begin
                        for (int i = 0; i < nch[d]; i++) owe[d][i] = 1'b1;
                        mword[d] = idata;
                    end else if (int'(isel) < nch[d]) begin
                        owe[d][isel] = 1'b1;
                        mword[d] = idata;
                    end else begin
                        merr[d] = 1'b1;
                        mcnt[d] = (mcnt[d] < 255) ? mcnt[d] + 1 : 255;
                    end
                end
            end
            if (act == d) last_acc = acc;
        end
        @(posedge clk);
        #1;
        chk("out_valid4", {28'b0, ov0}, {28'b0, mvalid(0)});
        chk("out_data4",  {24'b0, od0}, {24'b0, mword[0]});
        chk("err4",       {31'b0, err0}, {31'b0, merr[0]});
        chk("drop_cnt4",  {24'b0, cnt0}, mcnt[0]);
        chk("out_valid3", {29'b0, ov1}, {28'b0, mvalid(1)});
        chk("out_data3",  {24'b0, od1}, {24'b0, mword[1]});
        chk("err3",       {31'b0, err1}, {31'b0, merr[1]});
        chk("drop_cnt3",  {24'b0, cnt1}, mcnt[1]);
    endtask

    initial begin
        nch[0] = 4;
        nch[1] = 3;
        last_acc = 1'b0;
        act   = 0;
        rst_n = 1'b0;
        iv    = 1'b1;
        ibc   = 1'b0;
        eclr  = 1'b0;
        idata = 8'hEE;
        isel  = 2'd1;
        ordy  = 4'hF;

        // Reset held for two edges with In_Valid high.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov4",  {28'b0, ov0}, 32'h0);
        chk("rst_od4",  {24'b0, od0}, 32'h0);
        chk("rst_err4", {31'b0, err0}, 32'h0);
        chk("rst_cnt4", {24'b0, cnt0}, 32'h0);
        chk("rst_rdy4", {31'b0, rdy0}, 32'h1);
        chk("rst_ov3",  {29'b0, ov1}, 32'h0);
        model_clear(0);
        model_clear(1);
        rst_n = 1'b1;

        // Back-to-back steering.
        iv = 1'b1; idata = 8'hA5; isel = 2'd2; ordy = 4'hF;
        cyc();
        chk("steer1_ov", {28'b0, ov0}, 32'h4);
        chk("steer1_od", {24'b0, od0}, 32'hA5);
        idata = 8'h3C; isel = 2'd0;
        cyc();
        chk("steer2_ov", {28'b0, ov0}, 32'h1);
        chk("steer2_od", {24'b0, od0}, 32'h3C);
        iv = 1'b0;
        cyc();

        // Backpressure on channel 1, then release with a same-edge accept.
        iv = 1'b1; idata = 8'h77; isel = 2'd1; ordy = 4'b1101;
        cyc();
        iv = 1'b0;
        repeat (3) begin
            cyc();
            chk("bp_ov", {28'b0, ov0}, 32'h2);
            chk("bp_od", {24'b0, od0}, 32'h77);
        end
        iv = 1'b1; idata = 8'h88; isel = 2'd3; ordy = 4'hF;
        cyc();
        chk("bp_next_ov", {28'b0, ov0}, 32'h8);
        chk("bp_next_od", {24'b0, od0}, 32'h88);
        iv = 1'b0;
        cyc();

        // Staggered broadcast.
        iv = 1'b1; ibc = 1'b1; idata = 8'h5A; ordy = 4'h0;
        cyc();
        chk("bc_ov0", {28'b0, ov0}, 32'hF);
        iv = 1'b0; ibc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ordy = 4'b0001 << k;
            cyc();
            chk("bc_od", {24'b0, od0}, (k == 3) ? 32'h5A : 32'h5A);
        end
        chk("bc_ov_end", {28'b0, ov0}, 32'h0);

        // Out-of-range select on the 3-channel instance.
        act = 1; ordy = 4'hF; iv = 1'b1; isel = 2'd3; idata = 8'h11;
        cyc();
        chk("oor_ov",  {29'b0, ov1}, 32'h0);
        chk("oor_err", {31'b0, err1}, 32'h1);
        chk("oor_cnt", {24'b0, cnt1}, 32'h1);
        repeat (300) begin
            idata = 8'($urandom);
            cyc();
        end
        chk("sat_cnt", {24'b0, cnt1}, 32'd255);
        iv = 1'b0; eclr = 1'b1;
        cyc();
        chk("clr_err", {31'b0, err1}, 32'h0);
        chk("clr_cnt", {24'b0, cnt1}, 32'h0);
        iv = 1'b1;
        cyc();
        chk("clr_drop_err", {31'b0, err1}, 32'h1);
        chk("clr_drop_cnt", {24'b0, cnt1}, 32'h1);
        eclr = 1'b0; iv = 1'b0;

        // Reset in the middle of a broadcast.
        act = 0; iv = 1'b1; ibc = 1'b1; idata = 8'hC3; ordy = 4'h0;
        cyc();
        iv = 1'b0; ibc = 1'b0; ordy = 4'b0011;
        cyc();
        chk("mid_ov", {28'b0, ov0}, 32'hC);
        rst_n = 1'b0; ordy = 4'h0;
        cyc();
        chk("mid_rst_ov", {28'b0, ov0}, 32'h0);
        rst_n = 1'b1; ordy = 4'hF;
        repeat (3) begin
            cyc();
            chk("mid_after_ov", {28'b0, ov0}, 32'h0);
            chk("mid_after_od", {24'b0, od0}, 32'h0);
        end

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            act = d;
            last_acc = 1'b1;
            iv = 1'b0;
            for (int k = 0; k < 400; k++) begin
                if (!(iv && !last_acc)) begin
                    iv    = ($urandom_range(0, 2) != 0);
                    ibc   = ($urandom_range(0, 3) == 0);
                    isel  = 2'($urandom);
                    idata = 8'($urandom);
                end
                ordy  = 4'($urandom);
                eclr  = ($urandom_range(0, 15) == 0);
                rst_n = ($urandom_range(0, 63) != 0);
                cyc();
            end
            rst_n = 1'b1;
            eclr  = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/demux_n_hs.md
Name: demux_n_hs

Overview:
- Parametrised, registered 1-to-NCH demultiplexer with a valid/ready handshake on every port. It generalises the team's 1-to-2 combinational demux.
- Each accepted word is captured once and steered to one selected channel or broadcast to all channels. It is held until every targeted channel accepts it.
- Sits between the TAP data-register shift path and multiple downstream consumers (scan chains / debug registers). It adds out-of-range select detection with a sticky error and a drop counter.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- NCH, 4, number of output channels (2..16)
- SELW, 2, select width; must satisfy 2**SELW >= NCH (Sel values >= NCH are legal inputs, treated as errors)

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous active-low reset
- In_Data  input  WIDTH  upstream data word
- In_Valid  input  1  upstream word valid
- In_Ready  output  1  block can accept a word this cycle
- Sel  input  SELW  target channel, sampled with In_Data on acceptance
- Bcast  input  1  1 = send to all NCH channels (Sel ignored), sampled on acceptance
- Out_Data  output  WIDTH  held word, shared by all channels
- Out_Valid  output  NCH  one bit per channel = word pending for that channel
- Out_Ready  input  NCH  per-channel downstream ready
- Err  output  1  sticky: an out-of-range Sel was accepted
- Err_Clr  input  1  clears Err and Drop_Cnt
- Drop_Cnt  output  8  saturating count of dropped (out-of-range) words

Behaviour:
- Reset (Rst_n=0 at rising Clk edge) takes priority over everything, including Err_Clr. It sets Pend (internal NCH-bit pending mask)=0, Out_Data=0, Out_Valid=0, Err=0 and Drop_Cnt=0.
- Reset mid-transfer discards the held word with no partial delivery on later cycles.
- Out_Valid = Pend, registered; there is no combinational path from In_* to Out_*.
- Channel i completes in a cycle when Out_Valid[i] & Out_Ready[i]. Pend[i] clears at that edge.
- Define Done = Pend & Out_Ready. In_Ready = ((Pend & ~Out_Ready) == 0), combinational from Pend and Out_Ready only, never from In_Valid.
  - In_Ready is 1 when idle (Pend=0).
  - In_Ready is also 1 in the cycle the last pending channels are accepted.
- Accept = In_Valid & In_Ready. On Accept:
  - Bcast=1: Pend <= all ones; Out_Data <= In_Data.
  - Bcast=0 and Sel < NCH: Pend <= one-hot(Sel); Out_Data <= In_Data.
  - Bcast=0 and Sel >= NCH: word dropped. Pend <= 0 and Out_Data is unchanged. Err <= 1 and Drop_Cnt increments, saturating at 255.
- Without Accept: Pend <= Pend & ~Done, and Out_Data holds.
- Throughput: one word per cycle when downstream is always ready. Latency is 1 cycle from In accept to Out_Valid.
- Broadcast: each channel may accept in a different cycle. The word stays on Out_Data and Out_Valid[i] drops individually until all channels are done. The next word is accepted in the same cycle the final channel completes.
- Out_Data is stable while any Pend bit is set.
- Err_Clr=1 clears Err to 0 and Drop_Cnt to 0 at the edge.
  - If a drop occurs in the same cycle, the drop wins: Err=1, Drop_Cnt=1.
- In_Valid low or In_Ready low: Sel/Bcast/In_Data are ignored.
- Upstream must hold In_Data/Sel/Bcast stable while In_Valid=1 and In_Ready=0. The block does not check this.
- Out_Valid[i] never deasserts without Out_Ready[i], except via reset.

Test Plan:
- Reset: drive Rst_n=0 for 2 cycles with In_Valid=1 -> Out_Valid=0, Out_Data=0, Err=0, Drop_Cnt=0, In_Ready=1.
- Directed steering, NCH=4, Out_Ready=4'b1111: In_Data=8'hA5 with Sel=2, then 8'h3C with Sel=0 on back-to-back cycles.
  - Out_Valid=4'b0100 / Data A5 one cycle after the first word, then 4'b0001 / Data 3C on the next cycle.
  - In_Ready stays 1 throughout.
- Backpressure: Sel=1 with Out_Ready[1]=0 for 3 cycles.
  - Out_Valid=4'b0010 and Out_Data held for 3 cycles; In_Ready=0.
  - Out_Ready[1]=1 -> In_Ready=1 that cycle; a new word is accepted at the same edge.
- Broadcast staggered: Bcast=1, Data 8'h5A. Out_Ready asserted one channel per cycle (ch0..ch3).
  - Out_Valid goes 1111 -> 1110 -> 1100 -> 1000 -> 0000; Data stays 5A.
  - In_Ready=1 only in the ch3 cycle.
- Out-of-range: NCH=3, SELW=2, Sel=3 accepted.
  - Out_Valid stays 0, Err=1, Drop_Cnt=1.
  - 300 more drops -> Drop_Cnt=255.
  - Err_Clr=1 -> Err=0, Drop_Cnt=0. Err_Clr coinciding with a drop -> Err=1, Drop_Cnt=1.
- Reset mid-broadcast: Pend=1100, then Rst_n=0 -> Out_Valid=0 next edge; held word never reappears after Rst_n returns high.
